instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 147 ++++++++++++++
 tb/tb_instruction_fetch.sv | 529 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues one word read at a time to instruction memory
// and buffers returned words with their addresses in a 2-entry FIFO. The FIFO
// head is presented to the decoder. A pc_load redirect flushes the buffer and
// discards any read that is still in flight.
//
// Handshakes:
//   memory  : mem_req/mem_addr are held stable from issue until the cycle
//             mem_ack is seen high; mem_ack while mem_req is low is ignored.
//   decoder : the head entry transfers on every rising edge where ins_valid and
//             ins_ready are both high; ins/ins_pc hold while ins_valid is low.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    input  logic        pc_load,
    input  logic [31:0] pc_target,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // The buffer is fixed at two entries: the head lives in ins/ins_pc, the
    // second entry in buf1_*.
    localparam logic [1:0]  FULL        = DEPTH[1:0];
    localparam logic [31:0] RESET_FETCH = {RESET_PC[31:2], 2'b00};

    state_t      state;
    logic        started;
    logic [31:0] fetch_pc;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [31:0] buf1_word;
    logic [31:0] buf1_pc;
    logic        pop;
    logic        push;

    // A push only happens for a live read; reads abandoned by a redirect are
    // completed in DISCARD and never written into the buffer.
    assign pop       = ins_valid & ins_ready;
    assign push      = (state == WAIT) & mem_ack & ~pc_load;
    assign dbg_state = state;

    // Next occupancy: flush wins, simultaneous push and pop cancel.
    always_comb begin
        count_next = count;
        if (pc_load) begin
            count_next = 2'd0;
        end else if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Request FSM; started delays the first issue by one edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            started  <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= 32'h0000_0000;
        end else begin
            started <= 1'b1;
            case (state)
                IDLE: begin
                    if (started && !pc_load && (count < FULL)) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end else if (pc_load) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Next fetch address: redirect target (word aligned) or sequential after a push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_FETCH;
        end else if (pc_load) begin
            fetch_pc <= pc_target & ~32'h0000_0003;
        end else if (push) begin
            fetch_pc <= fetch_pc + 32'h0000_0004;
        end
    end

    // Two-entry buffer with the head registered directly on ins/ins_pc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            ins_valid <= 1'b0;
            ins       <= 32'h0000_0000;
            ins_pc    <= 32'h0000_0000;
            buf1_word <= 32'h0000_0000;
            buf1_pc   <= 32'h0000_0000;
        end else begin
            count     <= count_next;
            ins_valid <= (count_next != 2'd0);
            if (!pc_load) begin
                if (push && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
                    ins    <= mem_rdata;
                    ins_pc <= mem_addr;
                end else if (pop && (count == 2'd2)) begin
                    ins    <= buf1_word;
                    ins_pc <= buf1_pc;
                end
                if (push && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) begin
                    buf1_word <= mem_rdata;
                    buf1_pc   <= mem_addr;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios for reset, streaming,
// back-pressure, redirects and wrap-around, then a randomized run against a
// queue-based model of the fetch buffer.
`timescale 1ns/1ps
module tb_instruction_fetch;

    // ---------------- clock / reset / DUT ----------------
    logic        clk;
    logic        rst_n;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic        pc_load;
    logic [31:0] pc_target;
    logic [1:0]  dbg_state;

    logic        mem_req_w;
    logic [31:0] mem_addr_w;
    logic        mem_ack_w;
    logic [31:0] mem_rdata_w;
    logic [31:0] ins_w;
    logic [31:0] ins_pc_w;
    logic        ins_valid_w;
    logic        ins_ready_w;
    logic        pc_load_w;
    logic [31:0] pc_target_w;
    logic [1:0]  dbg_state_w;

    instruction_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .pc_load(pc_load), .pc_target(pc_target), .dbg_state(dbg_state)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w), .mem_ack(mem_ack_w), .mem_rdata(mem_rdata_w),
        .ins(ins_w), .ins_pc(ins_pc_w), .ins_valid(ins_valid_w), .ins_ready(ins_ready_w),
        .pc_load(pc_load_w), .pc_target(pc_target_w), .dbg_state(dbg_state_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bench state ----------------
    int          n_checks;
    int          n_pass;
    bit          auto_ack;
    int          ack_lat;
    int          req_cycles;
    logic        last_ack;
    logic [31:0] last_ack_addr;
    logic [31:0] got_pc_q[$];
    logic [31:0] got_word_q[$];
    logic [31:0] req_addr_q[$];
    logic [63:0] exp_q[$];

    // Memory contents: a fixed scramble of the address so each word is distinct.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = 32'h0;
        ins_ready   = 1'b0;
        pc_load     = 1'b0;
        pc_target   = 32'h0;
        mem_ack_w   = 1'b0;
        mem_rdata_w = 32'h0;
        ins_ready_w = 1'b0;
        pc_load_w   = 1'b0;
        pc_target_w = 32'h0;
        auto_ack    = 1'b1;
        ack_lat     = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        req_cycles = 0;
        last_ack   = 1'b0;
        got_pc_q.delete();
        got_word_q.delete();
        req_addr_q.delete();
    endtask

    // One cycle on the main DUT: record deliveries and new requests, answer
    // the request ack_lat cycles after it first appears, then advance.
    task automatic drive_cycle();
        if (mem_req) req_cycles++;
        else req_cycles = 0;
        if (ins_valid && ins_ready) begin
            got_pc_q.push_back(ins_pc);
            got_word_q.push_back(ins);
        end
        if (mem_req && req_cycles == 1) req_addr_q.push_back(mem_addr);
        if (auto_ack) begin
            mem_ack   = mem_req && (req_cycles == ack_lat + 1);
            mem_rdata = mem_ack ? word_of(mem_addr) : 32'h0;
        end
        last_ack      = mem_req && mem_ack;
        last_ack_addr = mem_addr;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_req, ins_valid, dbg_state} !== 4'b0000)
            $display("FAIL reset_ctrl: got req=%b valid=%b state=%0d expected 0 0 0", mem_req, ins_valid, dbg_state);
        else n_pass++;
        n_checks++;
        if ({mem_addr, ins, ins_pc} !== 96'h0)
            $display("FAIL reset_data: got addr=%h ins=%h pc=%h expected all zero", mem_addr, ins, ins_pc);
        else n_pass++;
        do_reset();
        drive_cycle();
        n_checks++;
        if (mem_req !== 1'b0) $display("FAIL first_req_edge1: got mem_req=%b expected 0", mem_req);
        else n_pass++;
        drive_cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            $display("FAIL first_req_edge2: got req=%b addr=%h expected 1 00000000", mem_req, mem_addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        ins_ready = 1'b1;
        for (int i = 0; i < 40 && got_pc_q.size() < 4; i++) begin
            drive_cycle();
            if (last_ack) begin
                n_checks++;
                if (ins_valid !== 1'b1 || ins_pc !== last_ack_addr)
                    $display("FAIL ack_to_valid: got valid=%b pc=%h expected 1 %h", ins_valid, ins_pc, last_ack_addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (got_pc_q.size() < 4) $display("FAIL stream_timeout: got %0d deliveries expected 4", got_pc_q.size());
        else begin
            n_pass++;
            for (int k = 0; k < 4; k++) begin
                n_checks++;
                if (got_pc_q[k] !== 32'(4 * k) || got_word_q[k] !== word_of(32'(4 * k)))
                    $display("FAIL stream_seq[%0d]: got pc=%h word=%h expected %h %h", k,
                             got_pc_q[k], got_word_q[k], 32'(4 * k), word_of(32'(4 * k)));
                else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        repeat (20) drive_cycle();
        n_checks++;
        if (req_addr_q.size() != 2 || mem_req !== 1'b0)
            $display("FAIL bp_requests: got %0d requests req=%b expected 2 0", req_addr_q.size(), mem_req);
        else n_pass++;
        n_checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h0 || ins !== word_of(32'h0))
            $display("FAIL bp_head: got valid=%b pc=%h ins=%h expected 1 00000000 %h", ins_valid, ins_pc, ins, word_of(32'h0));
        else n_pass++;
        ins_ready = 1'b1;
        for (int i = 0; i < 20 && (got_pc_q.size() < 2 || req_addr_q.size() < 3); i++) drive_cycle();
        n_checks++;
        if (got_pc_q.size() < 2 || req_addr_q.size() < 3)
            $display("FAIL bp_drain_timeout: got %0d deliveries %0d requests expected 2 3", got_pc_q.size(), req_addr_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (got_pc_q[0] !== 32'h0 || got_pc_q[1] !== 32'h4 || got_word_q[1] !== word_of(32'h4))
                $display("FAIL bp_order: got %h %h word1=%h expected 00000000 00000004 %h",
                         got_pc_q[0], got_pc_q[1], got_word_q[1], word_of(32'h4));
            else n_pass++;
            n_checks++;
            if (req_addr_q[2] !== 32'h8) $display("FAIL bp_resume: got addr %h expected 00000008", req_addr_q[2]);
            else n_pass++;
        end
    endtask

    task automatic test_load_latency();
        do_reset();
        repeat (20) drive_cycle();
        pc_load   = 1'b1;
        pc_target = 32'h0000_2007;
        drive_cycle();
        pc_load = 1'b0;
        n_checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0)
            $display("FAIL load_n1: got req=%b valid=%b expected 0 0", mem_req, ins_valid);
        else n_pass++;
        n_checks++;
        if (ins_pc !== 32'h0 || ins !== word_of(32'h0))
            $display("FAIL load_hold: got pc=%h ins=%h expected 00000000 %h", ins_pc, ins, word_of(32'h0));
        else n_pass++;
        drive_cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_2004)
            $display("FAIL load_n2: got req=%b addr=%h expected 1 00002004", mem_req, mem_addr);
        else n_pass++;
        repeat (3) drive_cycle();
        n_checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 32'h0000_2004 || ins !== word_of(32'h0000_2004))
            $display("FAIL load_deliver: got valid=%b pc=%h ins=%h expected 1 00002004 %h",
                     ins_valid, ins_pc, ins, word_of(32'h0000_2004));
        else n_pass++;
    endtask

    task automatic test_redirect_wait();
        bit found;
        bit saw8;
        do_reset();
        ins_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req && mem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
            drive_cycle();
        end
        n_checks++;
        if (!found) $display("FAIL redir_setup: got no request at 00000008 expected one");
        else n_pass++;
        ack_lat   = 2;
        pc_load   = 1'b1;
        pc_target = 32'h0000_0103;
        drive_cycle();
        pc_load = 1'b0;
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8)
            $display("FAIL redir_hold: got req=%b addr=%h expected 1 00000008", mem_req, mem_addr);
        else n_pass++;
        for (int i = 0; i < 6; i++) drive_cycle();
        ack_lat = 1;
        for (int i = 0; i < 20 && got_pc_q.size() < 3; i++) drive_cycle();
        saw8 = 1'b0;
        foreach (got_pc_q[k]) if (got_pc_q[k] == 32'h8) saw8 = 1'b1;
        n_checks++;
        if (saw8) $display("FAIL redir_drop: got pc 00000008 delivered expected dropped");
        else n_pass++;
        n_checks++;
        if (got_pc_q.size() < 3 || req_addr_q.size() < 4)
            $display("FAIL redir_timeout: got %0d deliveries %0d requests expected 3 4", got_pc_q.size(), req_addr_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (req_addr_q[3] !== 32'h100 || got_pc_q[2] !== 32'h100 || got_word_q[2] !== word_of(32'h100))
                $display("FAIL redir_target: got req=%h pc=%h word=%h expected 00000100 00000100 %h",
                         req_addr_q[3], got_pc_q[2], got_word_q[2], word_of(32'h100));
            else n_pass++;
        end
    endtask

    task automatic test_flush_collision();
        bit found;
        bit saw4;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (ins_valid && mem_req && mem_addr == 32'h4) begin
                found = 1'b1;
                break;
            end
            drive_cycle();
        end
        n_checks++;
        if (!found) $display("FAIL coll_setup: got no overlap of head and request 00000004 expected one");
        else n_pass++;
        auto_ack  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = word_of(32'h4);
        ins_ready = 1'b1;
        pc_load   = 1'b1;
        pc_target = 32'h0000_0040;
        drive_cycle();
        mem_ack  = 1'b0;
        pc_load  = 1'b0;
        auto_ack = 1'b1;
        n_checks++;
        if (ins_valid !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL coll_flush: got valid=%b req=%b expected 0 0", ins_valid, mem_req);
        else n_pass++;
        got_pc_q.delete();
        got_word_q.delete();
        req_addr_q.delete();
        for (int i = 0; i < 20 && got_pc_q.size() < 1; i++) drive_cycle();
        saw4 = 1'b0;
        foreach (got_pc_q[k]) if (got_pc_q[k] == 32'h4) saw4 = 1'b1;
        n_checks++;
        if (saw4) $display("FAIL coll_drop: got pc 00000004 delivered expected dropped");
        else n_pass++;
        n_checks++;
        if (got_pc_q.size() < 1 || req_addr_q.size() < 1)
            $display("FAIL coll_timeout: got %0d deliveries expected 1", got_pc_q.size());
        else begin
            n_pass++;
            n_checks++;
            if (req_addr_q[0] !== 32'h40 || got_pc_q[0] !== 32'h40 || got_word_q[0] !== word_of(32'h40))
                $display("FAIL coll_target: got req=%h pc=%h word=%h expected 00000040 00000040 %h",
                         req_addr_q[0], got_pc_q[0], got_word_q[0], word_of(32'h40));
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_request();
        bit found;
        do_reset();
        ins_ready = 1'b1;
        found     = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req && mem_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
            drive_cycle();
        end
        n_checks++;
        if (!found) $display("FAIL rstmid_setup: got no request at 00000008 expected one");
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, ins_valid} !== 2'b00 || {mem_addr, ins, ins_pc} !== 96'h0)
            $display("FAIL rstmid_async: got req=%b valid=%b addr=%h ins=%h pc=%h expected all zero",
                     mem_req, ins_valid, mem_addr, ins, ins_pc);
        else n_pass++;
        auto_ack  = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = word_of(32'h8);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({mem_req, ins_valid} !== 2'b00 || {mem_addr, ins, ins_pc} !== 96'h0)
            $display("FAIL rstmid_ack: got req=%b valid=%b addr=%h ins=%h pc=%h expected all zero",
                     mem_req, ins_valid, mem_addr, ins, ins_pc);
        else n_pass++;
        mem_ack    = 1'b0;
        auto_ack   = 1'b1;
        rst_n      = 1'b1;
        req_cycles = 0;
        got_pc_q.delete();
        got_word_q.delete();
        req_addr_q.delete();
        drive_cycle();
        n_checks++;
        if (mem_req !== 1'b0 || ins_valid !== 1'b0)
            $display("FAIL rstmid_edge1: got req=%b valid=%b expected 0 0", mem_req, ins_valid);
        else n_pass++;
        drive_cycle();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0)
            $display("FAIL rstmid_edge2: got req=%b addr=%h expected 1 00000000", mem_req, mem_addr);
        else n_pass++;
        for (int i = 0; i < 10 && got_pc_q.size() < 1; i++) drive_cycle();
        n_checks++;
        if (got_pc_q.size() < 1 || got_pc_q[0] !== 32'h0 || got_word_q[0] !== word_of(32'h0))
            $display("FAIL rstmid_first: got %0d deliveries first pc=%h expected 00000000",
                     got_pc_q.size(), got_pc_q.size() > 0 ? got_pc_q[0] : 32'hX);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int          rc;
        logic [31:0] exp_pc[3];
        logic [31:0] wpc_q[$];
        logic [31:0] wword_q[$];
        exp_pc[0] = 32'hFFFF_FFFC;
        exp_pc[1] = 32'h0000_0000;
        exp_pc[2] = 32'h0000_0004;
        do_reset();
        ins_ready_w = 1'b1;
        rc = 0;
        for (int i = 0; i < 40 && wpc_q.size() < 3; i++) begin
            if (mem_req_w) rc++;
            else rc = 0;
            if (ins_valid_w && ins_ready_w) begin
                wpc_q.push_back(ins_pc_w);
                wword_q.push_back(ins_w);
            end
            mem_ack_w   = mem_req_w && (rc == 2);
            mem_rdata_w = mem_ack_w ? word_of(mem_addr_w) : 32'h0;
            @(posedge clk);
            #1;
        end
        mem_ack_w = 1'b0;
        n_checks++;
        if (wpc_q.size() < 3) $display("FAIL wrap_timeout: got %0d deliveries expected 3", wpc_q.size());
        else begin
            n_pass++;
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (wpc_q[k] !== exp_pc[k] || wword_q[k] !== word_of(exp_pc[k]))
                    $display("FAIL wrap_seq[%0d]: got pc=%h word=%h expected %h %h", k,
                             wpc_q[k], wword_q[k], exp_pc[k], word_of(exp_pc[k]));
                else n_pass++;
            end
        end
    endtask

    // Randomized run: the model tracks the buffer as a queue of {pc, word},
    // the next fetch address, and whether the in-flight read was superseded.
    task automatic test_random();
        logic [31:0] mfpc;
        logic        outstanding;
        logic        stale;
        logic        just_acked;
        logic        push;
        logic [31:0] out_addr;
        logic        req;
        logic        v;
        logic [31:0] addr;
        logic [31:0] iw;
        logic [31:0] ip;
        do_reset();
        auto_ack    = 1'b0;
        exp_q.delete();
        mfpc        = 32'h0;
        outstanding = 1'b0;
        stale       = 1'b0;
        just_acked  = 1'b0;
        out_addr    = 32'h0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            req  = mem_req;
            v    = ins_valid;
            addr = mem_addr;
            iw   = ins;
            ip   = ins_pc;
            n_checks++;
            if (v !== (exp_q.size() != 0))
                $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, v, exp_q.size() != 0);
            else n_pass++;
            if (v && exp_q.size() != 0) begin
                n_checks++;
                if ({ip, iw} !== exp_q[0])
                    $display("FAIL rnd_head@%0d: got %h expected %h", cyc, {ip, iw}, exp_q[0]);
                else n_pass++;
            end
            if (req) begin
                if (!outstanding) begin
                    n_checks++;
                    if (addr !== mfpc || just_acked)
                        $display("FAIL rnd_issue@%0d: got addr=%h gapless=%b expected %h 0", cyc, addr, just_acked, mfpc);
                    else n_pass++;
                    outstanding = 1'b1;
                    out_addr    = addr;
                    stale       = 1'b0;
                end else begin
                    n_checks++;
                    if (addr !== out_addr)
                        $display("FAIL rnd_stable@%0d: got %h expected %h", cyc, addr, out_addr);
                    else n_pass++;
                end
            end else begin
                n_checks++;
                if (outstanding) $display("FAIL rnd_req_drop@%0d: got mem_req=0 expected 1", cyc);
                else n_pass++;
            end
            ins_ready = 1'($urandom_range(0, 1));
            pc_load   = ($urandom_range(0, 11) == 0);
            pc_target = $urandom;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = req ? word_of(addr) : $urandom;
            just_acked = req && mem_ack;
            push       = req && mem_ack && !pc_load && !stale;
            if (req && mem_ack) outstanding = 1'b0;
            else if (req && pc_load) stale = 1'b1;
            if (pc_load) begin
                exp_q.delete();
                mfpc = pc_target & ~32'h3;
            end else begin
                if (v && ins_ready && exp_q.size() != 0) void'(exp_q.pop_front());
                if (push) begin
                    exp_q.push_back({addr, word_of(addr)});
                    mfpc = mfpc + 32'h4;
                    n_checks++;
                    if (exp_q.size() > 2) $display("FAIL rnd_overflow@%0d: got %0d entries expected <=2", cyc, exp_q.size());
                    else n_pass++;
                end
            end
            @(posedge clk);
            #1;
        end
        mem_ack   = 1'b0;
        pc_load   = 1'b0;
        ins_ready = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        do_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_load_latency();
        test_redirect_wait();
        test_flush_collision();
        test_reset_mid_request();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
